uart_parity_engine: RTL and testbench
=====================================

Name: uart_parity_engine

Overview:
- Parametrised, registered parity generator/checker for the UART datapath. Successor to the combinational transmitter parity logic.
- Two ways to compute parity:
  - one-shot parallel load of a data word;
  - serial accumulation, one bit per cycle, as the TX shifter or RX sampler presents bits.
- Runtime parity modes (none/even/odd/mark/space).
- Checks a received parity bit and keeps a saturating error count. The same block serves both TX and RX frames.

Parameters:
- DATA_W, 8, data bits per frame; legal range 5..9.
- ERR_CNT_W, 8, width of the saturating parity-error counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  3  parity mode; sampled only on an accepted load or start.
- load  in  1  parallel request: compute parity of data.
- data  in  DATA_W  parallel data word; sampled with load.
- start  in  1  begin a serial accumulation.
- bit_valid  in  1  bit_in is valid this cycle; used in ACC only.
- bit_in  in  1  serial data bit, LSB first.
- chk_valid  in  1  chk_bit holds the received parity bit; compare now.
- chk_bit  in  1  received parity bit.
- clr_err  in  1  clear err_cnt.
- parity  out  1  computed parity bit; held until the next load/start.
- parity_valid  out  1  parity is valid for the current frame.
- busy  out  1  high in state ACC.
- err  out  1  one-cycle pulse on a parity mismatch.
- err_cnt  out  ERR_CNT_W  saturating count of mismatches.

Behaviour:
- Reset (synchronous) gives: state IDLE, acc=0, bit count=0, parity=0, parity_valid=0, busy=0, err=0, err_cnt=0, mode register=NONE. A reset during ACC abandons the frame; no parity_valid is produced.
- Parity function on raw = XOR of the DATA_W bits:
  - EVEN -> raw; ODD -> ~raw; MARK -> 1; SPACE -> 0; NONE -> 0.
  - Reserved mode codes are treated as NONE.
- Parallel path, from any state: load=1 at edge N gives parity and parity_valid=1 at N+1, with the mode latched at N. Latency is 1 cycle. An ACC in progress is aborted and busy drops at N+1.
- Serial FSM has three states: IDLE, ACC, DONE.
  - IDLE/DONE -> ACC on start (and load=0). Actions: acc cleared, count cleared, mode latched, parity_valid cleared, busy=1 next cycle.
  - In ACC, each bit_valid does acc ^= bit_in and count++. When count reaches DATA_W-1 and bit_valid=1, go to DONE. On that transition parity = f(acc ^ bit_in), parity_valid=1, busy=0, all registered in the same edge.
  - bit_valid while in IDLE/DONE is ignored.
  - start while in ACC restarts accumulation; the partial result is discarded.
- Priority: rst > load > start > bit_valid.
- Checker:
  - chk_valid is honoured only when parity_valid=1 and the latched mode is not NONE.
  - If chk_bit != parity, err=1 the next cycle and err_cnt increments, saturating at all-ones.
  - chk_valid while parity_valid=0 is ignored.
- err_cnt clearing: clr_err sets err_cnt to 0 next cycle. If clr_err and an increment coincide, clr_err wins and the result is 0.
- Width rule: count is $clog2(DATA_W+1) bits; no wrap occurs because ACC exits at DATA_W bits.

Decomposition:
- Shared package uart_pkg holds:
  - mode encodings: PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2, PAR_MARK=3, PAR_SPACE=4;
  - the state typedef for IDLE/ACC/DONE;
  - the DATA_W legal-range constants.
- One natural sub-module: uart_sat_counter (the ERR_CNT_W saturating counter with clear and increment). The parity function is a package function, not a module.

Test Plan:
- Parallel, EVEN, data=8'hA5 (4 ones), load=1 -> next cycle parity=0, parity_valid=1. Repeat in ODD -> parity=1.
- Serial, ODD, start then bits LSB-first of 8'h07 over 8 bit_valid cycles, with a 2-cycle gap inserted -> busy high throughout; parity=0 and parity_valid=1 on the edge of the 8th bit; busy=0.
- Check, EVEN, data=8'h01 (parity=1): chk_bit=0 -> err pulse, err_cnt=1. chk_bit=1 -> no err. Mode NONE with chk_bit=1 -> no err.
- Saturation with ERR_CNT_W=2: five mismatches -> err_cnt=3, held. Then clr_err coinciding with a mismatch -> err_cnt=0.
- Abort/reset: start, 3 bits, then load 8'hFF in MARK -> parity=1 next cycle, busy=0. Separately: start, 4 bits, rst -> all outputs 0, state IDLE, and later bit_valid is ignored.
- DATA_W=5, SPACE: serial 5'b11111 -> parity=0 after exactly 5 bits. A 6th bit_valid leaves parity and parity_valid unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART parity datapath: mode codes, FSM states,
// legal frame-width range and the parity function itself.
package uart_pkg;

  localparam int DATA_W_MIN = 5;
  localparam int DATA_W_MAX = 9;

  localparam logic [2:0] PAR_NONE  = 3'd0;
  localparam logic [2:0] PAR_EVEN  = 3'd1;
  localparam logic [2:0] PAR_ODD   = 3'd2;
  localparam logic [2:0] PAR_MARK  = 3'd3;
  localparam logic [2:0] PAR_SPACE = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Reserved codes collapse to NONE so the rest of the design only ever
  // sees the five defined modes.
  function automatic logic [2:0] mode_sanitize(input logic [2:0] m);
    return (m > PAR_SPACE) ? PAR_NONE : m;
  endfunction

  // Map the XOR of the data bits onto the parity bit for a given mode.
  function automatic logic parity_of(input logic raw, input logic [2:0] m);
    logic p;
    case (m)
      PAR_EVEN: p = raw;
      PAR_ODD:  p = ~raw;
      PAR_MARK: p = 1'b1;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_sat_counter.sv
// Saturating up-counter with a clear that always beats an increment.
module uart_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up on inc, stick at all-ones, return to zero on clear or reset.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_parity_engine.sv
// Registered parity generator/checker shared by the TX and RX frame paths.
// Parity comes either from a one-shot parallel load or from serial
// accumulation of DATA_W bits; a received parity bit can be compared
// against the held result, with mismatches counted.
module uart_parity_engine
  import uart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           mode,
  input  logic                 load,
  input  logic [DATA_W-1:0]    data,
  input  logic                 start,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  input  logic                 chk_valid,
  input  logic                 chk_bit,
  input  logic                 clr_err,
  output logic                 parity,
  output logic                 parity_valid,
  output logic                 busy,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_data_w_illegal
    $error("uart_parity_engine: DATA_W out of range");
  end

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic             acc;
  logic [2:0]       mode_q;
  logic             last_bit;
  logic             chk_mismatch;
  logic [2:0]       mode_in;

  assign mode_in      = mode_sanitize(mode);
  assign last_bit     = (state == ST_ACC) && bit_valid && (count == CNT_W'(DATA_W - 1));
  assign chk_mismatch = chk_valid && parity_valid && (mode_q != PAR_NONE) && (chk_bit != parity);

  // State register for the serial accumulation FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a parallel load finishes a frame from anywhere, start
  // (re)enters ACC, and the final serial bit closes the frame.
  always_comb begin
    state_next = state;
    if (load) begin
      state_next = ST_DONE;
    end else if (start) begin
      state_next = ST_ACC;
    end else if (last_bit) begin
      state_next = ST_DONE;
    end
  end

  // Busy simply reflects being mid-accumulation.
  always_comb begin
    busy = (state == ST_ACC);
  end

  // Datapath: mode latch, accumulator, bit count and the held parity result.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= PAR_NONE;
      acc          <= 1'b0;
      count        <= '0;
      parity       <= 1'b0;
      parity_valid <= 1'b0;
    end else if (load) begin
      mode_q       <= mode_in;
      acc          <= 1'b0;
      count        <= '0;
      parity       <= parity_of(^data, mode_in);
      parity_valid <= 1'b1;
    end else if (start) begin
      mode_q       <= mode_in;
      acc          <= 1'b0;
      count        <= '0;
      parity_valid <= 1'b0;
    end else if ((state == ST_ACC) && bit_valid) begin
      acc   <= acc ^ bit_in;
      count <= count + CNT_W'(1);
      if (last_bit) begin
        parity       <= parity_of(acc ^ bit_in, mode_q);
        parity_valid <= 1'b1;
      end
    end
  end

  // One-cycle error pulse whenever an honoured check disagrees.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= chk_mismatch;
    end
  end

  uart_sat_counter #(
    .W (ERR_CNT_W)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_err),
    .inc (chk_mismatch),
    .cnt (err_cnt)
  );

endmodule

// File: tb/tb_uart_parity_engine.sv
// Scoreboard bench for uart_parity_engine: an 8-bit instance with a 2-bit
// error counter driven by directed and random frames, plus a 5-bit instance
// for the short-frame boundary.
module tb_uart_parity_engine;

  localparam int K_PAR     = 0;
  localparam int K_NOVALID = 1;
  localparam int K_BUSY    = 2;
  localparam int K_ERR     = 3;

  typedef struct {
    int          cyc;
    int          kind;
    logic        exp;
    logic [7:0]  expCnt;
    string       name;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [2:0] mode;
  logic       load;
  logic [7:0] data;
  logic       start;
  logic       bit_valid;
  logic       bit_in;
  logic       chk_valid;
  logic       chk_bit;
  logic       clr_err;
  logic       parity;
  logic       parity_valid;
  logic       busy;
  logic       err;
  logic [1:0] err_cnt;

  logic [2:0] mode5;
  logic [4:0] data5;
  logic       start5;
  logic       bit_valid5;
  logic       bit_in5;
  logic       parity5;
  logic       parity_valid5;
  logic       busy5;
  logic       err5;
  logic [7:0] err_cnt5;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbQ[$];
  exp_t monE;

  logic mValid;
  logic mPar;
  logic mNone;
  int   mCnt;

  uart_parity_engine #(.DATA_W(8), .ERR_CNT_W(2)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .load(load), .data(data),
    .start(start), .bit_valid(bit_valid), .bit_in(bit_in),
    .chk_valid(chk_valid), .chk_bit(chk_bit), .clr_err(clr_err),
    .parity(parity), .parity_valid(parity_valid), .busy(busy),
    .err(err), .err_cnt(err_cnt)
  );

  uart_parity_engine #(.DATA_W(5), .ERR_CNT_W(8)) u_dut5 (
    .clk(clk), .rst(rst), .mode(mode5), .load(1'b0), .data(data5),
    .start(start5), .bit_valid(bit_valid5), .bit_in(bit_in5),
    .chk_valid(1'b0), .chk_bit(1'b0), .clr_err(1'b0),
    .parity(parity5), .parity_valid(parity_valid5), .busy(busy5),
    .err(err5), .err_cnt(err_cnt5)
  );

  // Free-running clock and cycle index used to timestamp expectations.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference rules written straight from the mode table.
  function automatic int effMode(input int m);
    return (m > 4) ? 0 : m;
  endfunction

  function automatic logic refParity(input int m, input int ones);
    case (effMode(m))
      1:       return logic'(ones % 2);
      2:       return logic'((ones % 2) == 0);
      3:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic pushExp(input int c, input int k, input logic e, input int cnt, input string nm);
    exp_t x;
    x.cyc = c; x.kind = k; x.exp = e; x.expCnt = 8'(cnt); x.name = nm;
    sbQ.push_back(x);
  endtask

  task automatic checkOutput(input string nm, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // One clock of stimulus; pulse inputs return to zero afterwards.
  task automatic applyStimulus(input logic rs, input logic ld, input logic st,
                               input logic bv, input logic bi, input logic cv,
                               input logic cb, input logic clr,
                               input logic [2:0] m, input logic [7:0] d);
    rst = rs; load = ld; start = st; bit_valid = bv; bit_in = bi;
    chk_valid = cv; chk_bit = cb; clr_err = clr; mode = m; data = d;
    @(posedge clk);
    #1;
    rst = 0; load = 0; start = 0; bit_valid = 0; bit_in = 0;
    chk_valid = 0; chk_bit = 0; clr_err = 0;
    mode = 3'($urandom_range(0, 7)); data = 8'($urandom);
  endtask

  task automatic doReset();
    pushExp(cyc + 1, K_NOVALID, 1'b0, 0, "reset valid");
    pushExp(cyc + 1, K_BUSY, 1'b0, 0, "reset busy");
    pushExp(cyc + 1, K_ERR, 1'b0, 0, "reset err");
    mValid = 0; mPar = 0; mNone = 1; mCnt = 0;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 8'd0);
  endtask

  task automatic doLoad(input int m, input logic [7:0] d, input logic withStart);
    logic p;
    p = refParity(m, $countones(d));
    pushExp(cyc + 1, K_PAR, p, 0, "load parity");
    pushExp(cyc + 1, K_BUSY, 1'b0, 0, "load busy");
    mValid = 1; mPar = p; mNone = (effMode(m) == 0);
    applyStimulus(0, 1, withStart, 0, 0, 0, 0, 0, 3'(m), d);
  endtask

  task automatic doStart(input int m);
    pushExp(cyc + 1, K_BUSY, 1'b1, 0, "start busy");
    pushExp(cyc + 1, K_NOVALID, 1'b0, 0, "start clears valid");
    mValid = 0; mNone = (effMode(m) == 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 3'(m), 8'($urandom));
  endtask

  task automatic doPartial(input int m, input logic [7:0] d, input int n);
    doStart(m);
    for (int i = 0; i < n; i++) begin
      pushExp(cyc + 1, K_BUSY, 1'b1, 0, "partial busy");
      applyStimulus(0, 0, 0, 1, d[i], 0, 0, 0, 3'($urandom), 8'($urandom));
    end
  endtask

  task automatic doSerial(input int m, input logic [7:0] d, input int gapAt, input int gapLen);
    logic p;
    p = refParity(m, $countones(d));
    doStart(m);
    for (int i = 0; i < 8; i++) begin
      if (i == gapAt) begin
        for (int g = 0; g < gapLen; g++) begin
          pushExp(cyc + 1, K_BUSY, 1'b1, 0, "gap busy");
          pushExp(cyc + 1, K_ERR, 1'b0, mCnt, "chk ignored in acc");
          applyStimulus(0, 0, 0, 0, 0, 1, 1'($urandom), 0, 3'($urandom), 8'($urandom));
        end
      end
      if (i < 7) begin
        pushExp(cyc + 1, K_BUSY, 1'b1, 0, "serial busy");
        pushExp(cyc + 1, K_NOVALID, 1'b0, 0, "serial not yet valid");
      end else begin
        pushExp(cyc + 1, K_PAR, p, 0, "serial parity");
        pushExp(cyc + 1, K_BUSY, 1'b0, 0, "serial done busy");
      end
      applyStimulus(0, 0, 0, 1, d[i], 0, 0, 0, 3'($urandom), 8'($urandom));
    end
    mValid = 1; mPar = p;
  endtask

  task automatic doCheck(input logic cb, input logic clr);
    logic e;
    e = mValid && !mNone && (cb != mPar);
    if (clr) mCnt = 0;
    else if (e && mCnt < 3) mCnt = mCnt + 1;
    pushExp(cyc + 1, K_ERR, e, mCnt, "check");
    applyStimulus(0, 0, 0, 0, 0, 1, cb, clr, 3'($urandom), 8'($urandom));
  endtask

  task automatic tick5(input logic st, input logic bv, input logic bi, input logic [2:0] m);
    start5 = st; bit_valid5 = bv; bit_in5 = bi; mode5 = m;
    @(posedge clk);
    #1;
    start5 = 0; bit_valid5 = 0; bit_in5 = 0;
  endtask

  // Monitor: compare every expectation whose cycle has arrived.
  always @(posedge clk) begin
    #1;
    while (sbQ.size() > 0 && sbQ[0].cyc <= cyc) begin
      monE = sbQ.pop_front();
      checks++;
      if (monE.cyc < cyc) begin
        errors++;
        $display("[TB] FAIL %s: stale entry for cycle %0d at cycle %0d", monE.name, monE.cyc, cyc);
      end else begin
        case (monE.kind)
          K_PAR: if (parity_valid !== 1'b1 || parity !== monE.exp) begin
            errors++;
            $display("[TB] FAIL %s: got valid=%b parity=%b expected valid=1 parity=%b",
                     monE.name, parity_valid, parity, monE.exp);
          end
          K_NOVALID: if (parity_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s: got valid=%b expected valid=0", monE.name, parity_valid);
          end
          K_BUSY: if (busy !== monE.exp) begin
            errors++;
            $display("[TB] FAIL %s: got busy=%b expected busy=%b", monE.name, busy, monE.exp);
          end
          default: if (err !== monE.exp || {6'd0, err_cnt} !== monE.expCnt) begin
            errors++;
            $display("[TB] FAIL %s: got err=%b cnt=%0d expected err=%b cnt=%0d",
                     monE.name, err, err_cnt, monE.exp, monE.expCnt);
          end
        endcase
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  // Stimulus sequence: directed cases first, then random frames, then the
  // 5-bit instance.
  initial begin
    logic [4:0] v5;
    rst = 1; load = 0; start = 0; bit_valid = 0; bit_in = 0; chk_valid = 0;
    chk_bit = 0; clr_err = 0; mode = 0; data = 0;
    mode5 = 0; data5 = 0; start5 = 0; bit_valid5 = 0; bit_in5 = 0;
    mValid = 0; mPar = 0; mNone = 1; mCnt = 0;

    doReset();
    doReset();
    checkOutput("reset parity", {7'd0, parity}, 8'd0);
    checkOutput("reset err_cnt", {6'd0, err_cnt}, 8'd0);
    checkOutput("reset busy", {7'd0, busy}, 8'd0);

    doLoad(1, 8'hA5, 0);
    doLoad(2, 8'hA5, 0);
    doSerial(2, 8'h07, 3, 2);

    doLoad(1, 8'h01, 0);
    doCheck(0, 0);
    doCheck(1, 0);
    doLoad(0, 8'h01, 0);
    doCheck(1, 0);
    doCheck(0, 0);

    doLoad(1, 8'h01, 0);
    for (int i = 0; i < 5; i++) doCheck(0, 0);
    doCheck(0, 1);
    doCheck(1, 0);

    doPartial(1, 8'h5A, 3);
    doLoad(3, 8'hFF, 0);
    doCheck(0, 0);

    doPartial(1, 8'h3C, 4);
    doReset();
    checkOutput("abort reset parity", {7'd0, parity}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      pushExp(cyc + 1, K_NOVALID, 1'b0, 0, "bit after reset ignored");
      pushExp(cyc + 1, K_BUSY, 1'b0, 0, "idle busy after reset");
      applyStimulus(0, 0, 0, 1, 1'($urandom), 0, 0, 0, 3'd1, 8'd0);
    end
    doCheck(1, 0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: doLoad($urandom_range(0, 7), 8'($urandom), 1'($urandom));
        1: doSerial($urandom_range(0, 7), 8'($urandom), $urandom_range(0, 8), $urandom_range(0, 3));
        2: begin
          doPartial($urandom_range(0, 7), 8'($urandom), $urandom_range(0, 7));
          doSerial($urandom_range(0, 7), 8'($urandom), 8, 0);
        end
        3: doPartial($urandom_range(0, 7), 8'($urandom), $urandom_range(1, 7));
        default: doCheck(1'($urandom), ($urandom_range(0, 5) == 0));
      endcase
      doCheck(1'($urandom), ($urandom_range(0, 7) == 0));
    end

    for (int i = 0; i < 20 && sbQ.size() > 0; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 8'd0);
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", sbQ.size());
    end

    doReset();
    checkOutput("dut5 reset valid", {7'd0, parity_valid5}, 8'd0);
    tick5(1, 0, 0, 3'd4);
    checkOutput("dut5 start busy", {7'd0, busy5}, 8'd1);
    for (int i = 0; i < 5; i++) begin
      tick5(0, 1, 1, 3'd1);
      if (i < 4) begin
        checkOutput("dut5 not valid before 5th bit", {7'd0, parity_valid5}, 8'd0);
        checkOutput("dut5 busy before 5th bit", {7'd0, busy5}, 8'd1);
      end
    end
    checkOutput("dut5 space parity", {7'd0, parity5}, 8'd0);
    checkOutput("dut5 space valid", {7'd0, parity_valid5}, 8'd1);
    checkOutput("dut5 space busy", {7'd0, busy5}, 8'd0);
    tick5(0, 1, 1, 3'd1);
    checkOutput("dut5 6th bit parity", {7'd0, parity5}, 8'd0);
    checkOutput("dut5 6th bit valid", {7'd0, parity_valid5}, 8'd1);

    v5 = 5'b10110;
    tick5(1, 0, 0, 3'd1);
    for (int i = 0; i < 5; i++) tick5(0, 1, v5[i], 3'd2);
    checkOutput("dut5 even parity", {7'd0, parity5}, 8'(refParity(1, $countones(v5))));
    checkOutput("dut5 even valid", {7'd0, parity_valid5}, 8'd1);
    tick5(0, 1, 1, 3'd2);
    checkOutput("dut5 even 6th bit parity", {7'd0, parity5}, 8'(refParity(1, $countones(v5))));
    checkOutput("dut5 err_cnt", err_cnt5, 8'd0);
    checkOutput("dut5 err", {7'd0, err5}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
